// File: rtl/power_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module : power_sched_pkg
// Brief  : Shared state encoding and component ids for the power scheduler.
// Rev    : 1.0
// ============================================================================
package power_sched_pkg;

    localparam int c_ps_width = 2;

    typedef enum logic [c_ps_width-1:0] {
        PS_IDLE   = 2'b00,
        PS_CHARGE = 2'b01,
        PS_ARB    = 2'b10,
        PS_GRANT  = 2'b11
    } ps_state_t;

    localparam logic [1:0] c_comp_airflow   = 2'b00;
    localparam logic [1:0] c_comp_thrusters = 2'b01;
    localparam logic [1:0] c_comp_solar     = 2'b10;

endpackage
`default_nettype wire

// File: rtl/power_sched_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_pick
// Brief  : Rotating-priority encoder: first set request at or above ptr, mod N.
// Rev    : 1.0
// ============================================================================
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] idx,
    output logic          any
);

    localparam int c_sw = PW + 1;

    logic [c_sw-1:0] w_pos;

    always_comb begin
        w_pos = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            // ptr + k never exceeds 2N-2, so one conditional subtract wraps it
            w_pos = {1'b0, ptr} + c_sw'(k);
            if (w_pos >= c_sw'(N)) begin
                w_pos = w_pos - c_sw'(N);
            end
            if (!any && req[w_pos[PW-1:0]]) begin
                idx = w_pos[PW-1:0];
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/power_sched.sv
`default_nettype none
// ============================================================================
// Module : power_sched
// Brief  : Shared-battery scheduler: solar charge accumulation, round-robin debits.
// Rev    : 1.0
// ============================================================================
module power_sched
    import power_sched_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int AMT_W      = 8,
    parameter int BATT_W     = 12,
    parameter int BATT_MAX   = 4000,
    parameter int BATT_INIT  = 2000,
    parameter int LOW_THRESH = 400
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   charge_valid,
    input  logic [AMT_W-1:0]       charge_amt,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AMT_W-1:0] req_amt,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       deny,
    output logic [AMT_W-1:0]       grant_amt,
    output logic [BATT_W-1:0]      batt,
    output logic                   low_batt,
    output logic                   brownout,
    output logic                   spill
);

    localparam int c_pw     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_pend_w = AMT_W + 2;
    localparam logic [BATT_W-1:0] c_batt_max  = BATT_W'(BATT_MAX);
    localparam logic [BATT_W-1:0] c_batt_init = BATT_W'(BATT_INIT);
    localparam logic [BATT_W-1:0] c_low       = BATT_W'(LOW_THRESH);

    ps_state_t           r_state, w_state_nxt;
    logic [BATT_W-1:0]   r_batt, w_batt_nxt;
    logic                r_low, r_brown, r_spill;
    logic [c_pend_w-1:0] r_pend;
    logic [c_pw-1:0]     r_ptr, r_winner;
    logic [N_REQ-1:0]    r_grant, r_deny;
    logic [AMT_W-1:0]    r_amt;

    logic [c_pend_w:0]   w_pend_sum;
    logic [BATT_W:0]     w_charge_sum;
    logic                w_clip;
    logic [c_pw-1:0]     w_pick_idx, w_ptr_src, w_ptr_inc;
    logic                w_pick_any;
    logic [AMT_W-1:0]    w_pick_amt;
    logic                w_fund;
    logic [N_REQ-1:0]    w_onehot;
    logic                w_commit, w_grant_go, w_deny_go, w_debit;

    rr_pick #(
        .N  (N_REQ),
        .PW (c_pw)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_pick_amt   = req_amt[w_pick_idx*AMT_W +: AMT_W];
    assign w_fund       = (r_batt >= BATT_W'(w_pick_amt));
    assign w_onehot     = N_REQ'(1) << w_pick_idx;
    assign w_pend_sum   = {1'b0, r_pend} + (c_pend_w+1)'(charge_amt);
    assign w_charge_sum = {1'b0, r_batt} + (BATT_W+1)'(r_pend);
    assign w_clip       = (w_charge_sum > (BATT_W+1)'(BATT_MAX));
    assign w_ptr_src    = w_debit ? r_winner : w_pick_idx;
    assign w_ptr_inc    = (w_ptr_src == c_pw'(N_REQ - 1)) ? '0 : w_ptr_src + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= PS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A charge pulse arriving in idle counts as pending charge, so charge wins the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_grant_go  = 1'b0;
        w_deny_go   = 1'b0;
        w_debit     = 1'b0;
        case (r_state)
            PS_IDLE: begin
                if ((r_pend != '0) || charge_valid) begin
                    w_state_nxt = PS_CHARGE;
                end else if (|req) begin
                    w_state_nxt = PS_ARB;
                end
            end
            PS_CHARGE: begin
                w_commit    = 1'b1;
                w_state_nxt = PS_IDLE;
            end
            PS_ARB: begin
                if (!w_pick_any) begin
                    w_state_nxt = PS_IDLE;
                end else if (w_fund) begin
                    w_grant_go  = 1'b1;
                    w_state_nxt = PS_GRANT;
                end else begin
                    w_deny_go   = 1'b1;
                    w_state_nxt = PS_IDLE;
                end
            end
            PS_GRANT: begin
                w_debit     = 1'b1;
                w_state_nxt = PS_IDLE;
            end
            default: w_state_nxt = PS_IDLE;
        endcase
    end

    always_comb begin
        w_batt_nxt = r_batt;
        if (w_commit) begin
            w_batt_nxt = w_clip ? c_batt_max : w_charge_sum[BATT_W-1:0];
        end else if (w_debit) begin
            w_batt_nxt = r_batt - BATT_W'(r_amt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_batt   <= c_batt_init;
            r_low    <= (c_batt_init < c_low);
            r_pend   <= '0;
            r_ptr    <= '0;
            r_winner <= '0;
            r_grant  <= '0;
            r_deny   <= '0;
            r_amt    <= '0;
            r_brown  <= 1'b0;
            r_spill  <= 1'b0;
        end else begin
            // The commit cycle restarts accumulation so a concurrent pulse is kept
            if (w_commit) begin
                r_pend <= charge_valid ? c_pend_w'(charge_amt) : '0;
            end else if (charge_valid) begin
                r_pend <= w_pend_sum[c_pend_w] ? '1 : w_pend_sum[c_pend_w-1:0];
            end
            r_batt  <= w_batt_nxt;
            r_low   <= (w_batt_nxt < c_low);
            r_spill <= w_commit & w_clip;
            r_grant <= w_grant_go ? w_onehot : '0;
            r_deny  <= w_deny_go ? w_onehot : '0;
            if (w_grant_go) begin
                r_amt    <= w_pick_amt;
                r_winner <= w_pick_idx;
            end
            if (w_deny_go) begin
                r_winner <= w_pick_idx;
                r_brown  <= 1'b1;
                r_ptr    <= w_ptr_inc;
            end
            if (w_debit) begin
                r_brown <= 1'b0;
                r_ptr   <= w_ptr_inc;
            end
        end
    end

    assign grant     = r_grant;
    assign deny      = r_deny;
    assign grant_amt = (|r_grant) ? r_amt : '0;
    assign batt      = r_batt;
    assign low_batt  = r_low;
    assign brownout  = r_brown;
    assign spill     = r_spill;

endmodule
`default_nettype wire

// File: tb/tb_power_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_power_sched
// Brief  : Directed plus randomized checks of power_sched against a battery model.
// Rev    : 1.0
// ============================================================================
module tb_power_sched;

    localparam int N    = 3;
    localparam int BMAX = 4000;
    localparam int BINI = 2000;
    localparam int LOW  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        charge_valid;
    logic [7:0]  charge_amt;
    logic [2:0]  req;
    logic [23:0] req_amt;
    logic [2:0]  grant, deny;
    logic [7:0]  grant_amt;
    logic [11:0] batt;
    logic        low_batt, brownout, spill;

    always #5 clk = ~clk;

    power_sched dut (
        .clk          (clk),
        .rst          (rst),
        .charge_valid (charge_valid),
        .charge_amt   (charge_amt),
        .req          (req),
        .req_amt      (req_amt),
        .grant        (grant),
        .deny         (deny),
        .grant_amt    (grant_amt),
        .batt         (batt),
        .low_batt     (low_batt),
        .brownout     (brownout),
        .spill        (spill)
    );

    int n_pass = 0;
    int n_chk  = 0;
    int mbatt, mptr;
    int mbrown;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_batt"}, 32'(batt), mbatt);
        chk({tag, "_low"}, 32'(low_batt), (mbatt < LOW) ? 1 : 0);
        chk({tag, "_brown"}, 32'(brownout), mbrown);
    endtask

    task automatic model_reset();
        mbatt  = BINI;
        mptr   = 0;
        mbrown = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        charge_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Serve one set of requests; the model decides every grant/deny from the rules.
    task automatic run_round(input logic [2:0] set, input int a0, input int a1, input int a2,
                             input bit hold, input int max_ev);
        logic [2:0] kept;
        int amts [3];
        int ev, cyc, w;
        kept = '0; ev = 0; cyc = 0;
        amts[0] = a0; amts[1] = a1; amts[2] = a2;
        req_amt = {8'(a2), 8'(a1), 8'(a0)};
        req = set;
        while (req != '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (grant != '0 || deny != '0) begin
                w = 0;
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(mptr + k) % N]) w = (mptr + k) % N;
                end
                mptr = (w + 1) % N;
                ev++;
                if (mbatt >= amts[w]) begin
                    chk("grant", 32'(grant), 1 << w);
                    chk("grant_no_deny", 32'(deny), 0);
                    chk("grant_amt", 32'(grant_amt), amts[w]);
                    mbatt  = mbatt - amts[w];
                    mbrown = 0;
                    if (!hold) req[w] = 1'b0;
                    if (hold && ev >= max_ev) req = '0;
                    @(negedge clk);
                    cyc++;
                    chk_state("after_grant");
                end else begin
                    chk("deny", 32'(deny), 1 << w);
                    chk("deny_no_grant", 32'(grant), 0);
                    chk("deny_amt_zero", 32'(grant_amt), 0);
                    mbrown = 1;
                    chk_state("after_deny");
                    if (!hold) begin
                        if (kept[w] || $urandom_range(0, 1) == 0) req[w] = 1'b0;
                        else kept[w] = 1'b1;
                    end
                    if (hold && ev >= max_ev) req = '0;
                end
            end
        end
        chk("round_done", 32'(req), 0);
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic charge_burst(input int n, input int fixed);
        int sum, a, tot;
        bit sp;
        sum = 0; sp = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(negedge clk);
                if (spill) sp = 1'b1;
                charge_valid = 1'b0;
            end
            @(negedge clk);
            if (spill) sp = 1'b1;
            a = (fixed >= 0) ? fixed : int'($urandom_range(0, 255));
            charge_valid = 1'b1;
            charge_amt   = 8'(a);
            sum += a;
        end
        @(negedge clk);
        if (spill) sp = 1'b1;
        charge_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (spill) sp = 1'b1;
        end
        tot   = mbatt + sum;
        mbatt = (tot > BMAX) ? BMAX : tot;
        chk("charge_batt", 32'(batt), mbatt);
        chk("charge_spill", 32'(sp), (tot > BMAX) ? 1 : 0);
        chk("charge_low", 32'(low_batt), (mbatt < LOW) ? 1 : 0);
    endtask

    task automatic set_batt(input int target);
        while (mbatt < target)
            charge_burst(1, (target - mbatt > 255) ? 255 : target - mbatt);
        while (mbatt > target)
            run_round(3'b001, (mbatt - target > 255) ? 255 : mbatt - target, 0, 0, 1'b0, 0);
    endtask

    function automatic int pick_amt();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 0;
        if (r == 1) return (mbatt > 255) ? 255 : mbatt;
        return int'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [2:0] set;
        rst = 1'b1; charge_valid = 1'b0; charge_amt = '0; req = '0; req_amt = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_batt", 32'(batt), BINI);
        chk("rst_low", 32'(low_batt), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_deny", 32'(deny), 0);
        chk("rst_gamt", 32'(grant_amt), 0);
        chk("rst_brown", 32'(brownout), 0);
        chk("rst_spill", 32'(spill), 0);
        rst = 1'b0;

        // Basic grant with fixed latency
        @(negedge clk);
        req = 3'b001; req_amt = {8'd0, 8'd0, 8'd50};
        @(negedge clk);
        chk("t1_no_early_grant", 32'(grant), 0);
        @(negedge clk);
        chk("t1_grant", 32'(grant), 3'b001);
        chk("t1_gamt", 32'(grant_amt), 50);
        req = '0;
        @(negedge clk);
        chk("t1_batt", 32'(batt), 1950);
        mbatt = 1950; mptr = 1;
        repeat (2) @(negedge clk);

        // Round-robin with all three held
        do_reset();
        run_round(3'b111, 10, 10, 10, 1'b1, 4);
        chk("t2_batt", 32'(batt), 1960);

        // Deny, then exact-amount grant, then zero-amount grant
        set_batt(30);
        run_round(3'b010, 0, 31, 0, 1'b0, 0);
        chk("t3_deny_batt", 32'(batt), 30);
        chk("t3_brown", 32'(brownout), 1);
        run_round(3'b010, 0, 30, 0, 1'b0, 0);
        chk("t3_exact_batt", 32'(batt), 0);
        chk("t3_brown_clr", 32'(brownout), 0);
        run_round(3'b100, 0, 0, 0, 1'b0, 0);
        run_round(3'b001, 1, 0, 0, 1'b0, 0);

        // Saturation and charges arriving during arbitration and grant
        set_batt(3990);
        charge_burst(1, 20);
        chk("t4_sat", 32'(batt), 4000);
        set_batt(3000);
        @(negedge clk);
        req = 3'b001; req_amt = {8'd0, 8'd0, 8'd100};
        @(negedge clk);
        chk("t4_arb_no_grant", 32'(grant), 0);
        charge_valid = 1'b1; charge_amt = 8'd5;
        @(negedge clk);
        chk("t4_grant", 32'(grant), 3'b001);
        charge_amt = 8'd7; req = '0;
        @(negedge clk);
        charge_valid = 1'b0;
        chk("t4_debit", 32'(batt), 2900);
        repeat (3) @(negedge clk);
        chk("t4_pend_commit", 32'(batt), 2912);
        mbatt = 2912; mptr = 1; mbrown = 0;

        // Charge and request in the same idle cycle: charge commits first
        @(negedge clk);
        charge_valid = 1'b1; charge_amt = 8'd10;
        req = 3'b001; req_amt = {8'd0, 8'd0, 8'd50};
        @(negedge clk);
        charge_valid = 1'b0;
        chk("t5_no_grant_1", 32'(grant), 0);
        @(negedge clk);
        chk("t5_charge_first", 32'(batt), 2922);
        chk("t5_no_grant_2", 32'(grant), 0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_grant", 32'(grant), 3'b001);
        req = '0;
        @(negedge clk);
        chk("t5_batt", 32'(batt), 2872);
        mbatt = 2872; mptr = 1;
        repeat (2) @(negedge clk);

        // Async reset during the grant cycle
        req = 3'b001; req_amt = {8'd0, 8'd0, 8'd100};
        @(negedge clk);
        @(negedge clk);
        chk("t6_grant", 32'(grant), 3'b001);
        rst = 1'b1;
        #1;
        chk("t6_grant_drop", 32'(grant), 0);
        chk("t6_batt", 32'(batt), BINI);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_state("t6_after");

        // Randomized mix of charge bursts and request rounds
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                charge_burst(int'($urandom_range(1, 4)), -1);
            end else begin
                set = 3'($urandom_range(1, 7));
                run_round(set, pick_amt(), pick_amt(), pick_amt(), 1'b0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
